mesh_router_xy: RTL

- Parametrised mesh router node: five channels (PE, east, west, north, south), each with an input FIFO of configurable depth.
- Uses XY dimension-order routing from header coordinates.
- Each output has a round-robin arbiter and a registered output stage.
- Intended as the drop-in node for an N×M generated mesh, replacing fixed per-row router instances.

---
 rtl/mesh_router_xy.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mesh_router_xy.sv
// mesh_router_xy: five-port XY mesh router node with input FIFOs, invalid-destination
// dropping and round-robin arbitrated, registered outputs.
module mesh_router_xy #(
  parameter int PACKET_WIDTH = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int COORD_W      = 2,
  parameter int X_POS        = 0,
  parameter int Y_POS        = 0,
  parameter int MESH_COLS    = 4,
  parameter int MESH_ROWS    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4:0]                si,
  output logic [4:0]                ri,
  input  logic [5*PACKET_WIDTH-1:0] di,
  output logic [4:0]                so,
  input  logic [4:0]                ro,
  output logic [5*PACKET_WIDTH-1:0] dout,
  output logic [7:0]                drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic [PACKET_WIDTH-1:0] mem [5][FIFO_DEPTH];
  logic [AW-1:0] wp [5];
  logic [AW-1:0] rp [5];
  logic [AW:0] cnt [5];
  logic [PACKET_WIDTH-1:0] head [5];
  logic [2:0] route [5];
  logic [2:0] ptr [5];
  logic [2:0] gnt [5];
  logic [4:0] req [5];
  logic [4:0] hv, drop, push, pop, gv;
  logic [3:0] nd;
  logic [8:0] dsum;

  for (genvar k = 0; k < 5; k++) begin : g_in
    logic [COORD_W-1:0] dx, dy;
    assign head[k] = mem[k][rp[k]];
    assign dx = head[k][PACKET_WIDTH-1 -: COORD_W];
    assign dy = head[k][PACKET_WIDTH-1-COORD_W -: COORD_W];
    assign hv[k] = cnt[k] != '0;
    assign ri[k] = cnt[k] != FULL;
    assign push[k] = si[k] && ri[k];
    assign drop[k] = hv[k] && (int'(dx) >= MESH_COLS || int'(dy) >= MESH_ROWS);
    assign route[k] = int'(dx) > X_POS ? 3'd1 : int'(dx) < X_POS ? 3'd2 :
                      int'(dy) > Y_POS ? 3'd3 : int'(dy) < Y_POS ? 3'd4 : 3'd0;
  end

  always_comb begin
    for (int o = 0; o < 5; o++) begin
      req[o] = '0;
      for (int k = 0; k < 5; k++) req[o][k] = hv[k] && !drop[k] && route[k] == 3'(o);
    end
  end

  // descending scan so the requester closest to ptr wins
  always_comb begin
    for (int o = 0; o < 5; o++) begin
      gv[o] = 1'b0;
      gnt[o] = ptr[o];
      for (int i = 4; i >= 0; i--) begin
        if (req[o][3'((int'(ptr[o]) + i) % 5)]) begin
          gv[o] = !so[o] || ro[o];
          gnt[o] = 3'((int'(ptr[o]) + i) % 5);
        end
      end
    end
  end

  always_comb begin
    pop = drop;
    nd = '0;
    for (int k = 0; k < 5; k++) begin
      nd = nd + 4'(drop[k]);
      for (int o = 0; o < 5; o++) if (gv[o] && gnt[o] == 3'(k)) pop[k] = 1'b1;
    end
  end

  assign dsum = 9'(drop_cnt) + 9'(nd);

  always_ff @(posedge clk) begin
    for (int k = 0; k < 5; k++)
      if (push[k]) mem[k][wp[k]] <= di[k*PACKET_WIDTH +: PACKET_WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 5; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
        cnt[k] <= '0;
      end
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (push[k]) wp[k] <= wp[k] + 1'b1;
        if (pop[k]) rp[k] <= rp[k] + 1'b1;
        cnt[k] <= cnt[k] + (AW+1)'(push[k]) - (AW+1)'(pop[k]);
      end
      drop_cnt <= dsum > 9'd255 ? 8'hff : dsum[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      so <= '0;
      dout <= '0;
      for (int o = 0; o < 5; o++) ptr[o] <= '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (gv[o]) begin
          so[o] <= 1'b1;
          dout[o*PACKET_WIDTH +: PACKET_WIDTH] <= head[gnt[o]];
          ptr[o] <= gnt[o] == 3'd4 ? 3'd0 : gnt[o] + 3'd1;
        end else if (ro[o]) so[o] <= 1'b0;
      end
    end
  end
endmodule
